// File: rtl/port_if.sv
// port_if: one bidirectional switch port bundle.
// Ports: clk, rst_n (asynchronous, active-high reset).
// Signals: valid/source/target/data in each direction.
// Modports: master is the traffic endpoint and slave is the switch side.
interface port_if (input logic clk, input logic rst_n);
    logic       valid_in;
    logic [3:0] source_in;
    logic [3:0] target_in;
    logic [7:0] data_in;
    logic       valid_out;
    logic [3:0] source_out;
    logic [3:0] target_out;
    logic [7:0] data_out;
    modport master (
        input  clk, rst_n,
        output valid_in, source_in, target_in, data_in,
        input  valid_out, source_out, target_out, data_out
    );
    modport slave (
        input  clk, rst_n,
        input  valid_in, source_in, target_in, data_in,
        output valid_out, source_out, target_out, data_out
    );
endinterface

// File: rtl/switch_4port.sv
// switch_4port: 4-port multicast packet switch with per-input FIFOs and an all-or-nothing round-robin allocator.
// Ports: clk; rst_n (asynchronous, active-high despite the name); port0..port3 (port_if.slave).
// Each input queues {source, target, data}. Each output carries at most one packet per cycle.
module switch_4port #(
    parameter int FIFO_DEPTH = 4
) (
    input logic   clk,
    input logic   rst_n,
    port_if.slave port0,
    port_if.slave port1,
    port_if.slave port2,
    port_if.slave port3
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [3:0]  v_in, hv, grant, claimed, sel_v, v_out;
    logic [15:0] pkt_in [4];
    logic [15:0] head [4];
    logic [15:0] sel_pkt [4];
    logic [15:0] pkt_out [4];
    logic [1:0]  rr_ptr, rr_next, idx;
    logic        found;
    assign v_in = {port3.valid_in, port2.valid_in, port1.valid_in, port0.valid_in};
    assign pkt_in[0] = {port0.source_in, port0.target_in, port0.data_in};
    assign pkt_in[1] = {port1.source_in, port1.target_in, port1.data_in};
    assign pkt_in[2] = {port2.source_in, port2.target_in, port2.data_in};
    assign pkt_in[3] = {port3.source_in, port3.target_in, port3.data_in};
    for (genvar q = 0; q < 4; q++) begin : g_q
        logic [15:0]   mem [FIFO_DEPTH];
        logic [AW-1:0] wr, rd;
        logic [AW:0]   cnt;
        logic          push;
        // A full queue drops the arrival even if its head pops on the same edge.
        assign push = v_in[q] && pkt_in[q][11:8] != 4'b0000 && cnt != (AW+1)'(FIFO_DEPTH);
        assign hv[q] = cnt != '0;
        assign head[q] = mem[rd];
        always_ff @(posedge clk)
            if (push) mem[wr] <= pkt_in[q];
        always_ff @(posedge clk or posedge rst_n)
            if (rst_n) begin
                wr  <= '0;
                rd  <= '0;
                cnt <= '0;
            end else begin
                wr  <= wr + AW'(push);
                rd  <= rd + AW'(grant[q]);
                cnt <= cnt + (AW+1)'(push) - (AW+1)'(grant[q]);
            end
    end
    // Scan heads from rr_ptr. A head wins only if none of its targets is already claimed.
    always_comb begin
        grant   = '0;
        claimed = '0;
        rr_next = rr_ptr;
        found   = 1'b0;
        idx     = rr_ptr;
        for (int i = 0; i < 4; i++) begin
            idx = rr_ptr + 2'(i);
            if (hv[idx] && (head[idx][11:8] & claimed) == 4'b0000) begin
                grant[idx] = 1'b1;
                claimed    = claimed | head[idx][11:8];
                if (!found) rr_next = idx + 2'd1;
                found = 1'b1;
            end
        end
    end
    always_comb begin
        sel_v = '0;
        for (int k = 0; k < 4; k++) begin
            sel_pkt[k] = '0;
            for (int i = 0; i < 4; i++)
                if (grant[i] && head[i][8+k]) begin
                    sel_v[k]   = 1'b1;
                    sel_pkt[k] = head[i];
                end
        end
    end
    always_ff @(posedge clk or posedge rst_n)
        if (rst_n) begin
            rr_ptr <= '0;
            v_out  <= '0;
            for (int k = 0; k < 4; k++) pkt_out[k] <= '0;
        end else begin
            rr_ptr <= rr_next;
            v_out  <= sel_v;
            for (int k = 0; k < 4; k++)
                if (sel_v[k]) pkt_out[k] <= sel_pkt[k];
        end
    assign port0.valid_out = v_out[0];
    assign port1.valid_out = v_out[1];
    assign port2.valid_out = v_out[2];
    assign port3.valid_out = v_out[3];
    assign {port0.source_out, port0.target_out, port0.data_out} = pkt_out[0];
    assign {port1.source_out, port1.target_out, port1.data_out} = pkt_out[1];
    assign {port2.source_out, port2.target_out, port2.data_out} = pkt_out[2];
    assign {port3.source_out, port3.target_out, port3.data_out} = pkt_out[3];
endmodule

// File: tb/tb_switch_4port.sv
// tb_switch_4port: directed self-checking bench for switch_4port.
module tb_switch_4port;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;
    port_if p0 (.clk(clk), .rst_n(rst_n));
    port_if p1 (.clk(clk), .rst_n(rst_n));
    port_if p2 (.clk(clk), .rst_n(rst_n));
    port_if p3 (.clk(clk), .rst_n(rst_n));
    switch_4port #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .port0(p0), .port1(p1), .port2(p2), .port3(p3)
    );
    logic [3:0]  ov;
    logic [31:0] od;
    logic [15:0] os, ot;
    assign ov = {p3.valid_out, p2.valid_out, p1.valid_out, p0.valid_out};
    assign od = {p3.data_out, p2.data_out, p1.data_out, p0.data_out};
    assign os = {p3.source_out, p2.source_out, p1.source_out, p0.source_out};
    assign ot = {p3.target_out, p2.target_out, p1.target_out, p0.target_out};

    task automatic drive(input int p, input logic [3:0] t, input logic [7:0] d);
        logic [3:0] s;
        s = 4'b0001 << p;
        case (p)
            0: begin p0.valid_in = 1'b1; p0.source_in = s; p0.target_in = t; p0.data_in = d; end
            1: begin p1.valid_in = 1'b1; p1.source_in = s; p1.target_in = t; p1.data_in = d; end
            2: begin p2.valid_in = 1'b1; p2.source_in = s; p2.target_in = t; p2.data_in = d; end
            default: begin p3.valid_in = 1'b1; p3.source_in = s; p3.target_in = t; p3.data_in = d; end
        endcase
    endtask

    task automatic idle();
        p0.valid_in = 1'b0;
        p1.valid_in = 1'b0;
        p2.valid_in = 1'b0;
        p3.valid_in = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++; if (ov !== 4'b0000) begin failures++; $display("FAIL rst_valid got=%b exp=0000", ov); end
        checks++; if (od !== 32'h0) begin failures++; $display("FAIL rst_data got=%h exp=00000000", od); end
        checks++; if ({os, ot} !== 32'h0) begin failures++; $display("FAIL rst_src_tgt got=%h exp=00000000", {os, ot}); end
        drive(0, 4'b0010, 8'h99);
        tick();
        idle();
        tick();
        rst_n = 1'b0;
        for (int n = 0; n < 4; n++) begin
            tick();
            checks++; if (ov !== 4'b0000) begin failures++; $display("FAIL rst_ignore got=%b exp=0000 cyc=%0d", ov, n); end
        end
    endtask

    task automatic test_unicast();
        drive(0, 4'b0010, 8'h5A);
        tick();
        idle();
        checks++; if (ov !== 4'b0000) begin failures++; $display("FAIL uni_early got=%b exp=0000", ov); end
        tick();
        checks++; if (ov !== 4'b0010) begin failures++; $display("FAIL uni_valid got=%b exp=0010", ov); end
        checks++; if (od[15:8] !== 8'h5A) begin failures++; $display("FAIL uni_data got=%h exp=5a", od[15:8]); end
        checks++; if (os[7:4] !== 4'b0001 || ot[7:4] !== 4'b0010) begin failures++; $display("FAIL uni_fields got=%b/%b exp=0001/0010", os[7:4], ot[7:4]); end
        tick();
        checks++; if (ov !== 4'b0000) begin failures++; $display("FAIL uni_pulse got=%b exp=0000", ov); end
        checks++; if (od[15:8] !== 8'h5A) begin failures++; $display("FAIL uni_hold got=%h exp=5a", od[15:8]); end
    endtask

    task automatic test_multicast_clash();
        do_reset();
        drive(0, 4'b1100, 8'hA0);
        drive(1, 4'b1100, 8'hB0);
        tick();
        idle();
        tick();
        checks++; if (ov !== 4'b1100) begin failures++; $display("FAIL clash_v1 got=%b exp=1100", ov); end
        checks++; if (od[31:16] !== 16'hA0A0 || os[15:8] !== 8'h11) begin failures++; $display("FAIL clash_d1 got=%h/%h exp=a0a0/11", od[31:16], os[15:8]); end
        tick();
        checks++; if (ov !== 4'b1100) begin failures++; $display("FAIL clash_v2 got=%b exp=1100", ov); end
        checks++; if (od[31:16] !== 16'hB0B0 || os[15:8] !== 8'h22) begin failures++; $display("FAIL clash_d2 got=%h/%h exp=b0b0/22", od[31:16], os[15:8]); end
        tick();
        checks++; if (ov !== 4'b0000) begin failures++; $display("FAIL clash_end got=%b exp=0000", ov); end
    endtask

    task automatic test_bcast_vs_unicast();
        drive(2, 4'b1111, 8'hFF);
        drive(3, 4'b0001, 8'h33);
        tick();
        idle();
        tick();
        checks++; if (ov !== 4'b1111 || od !== 32'hFFFFFFFF) begin failures++; $display("FAIL bcast_all got=%b/%h exp=1111/ffffffff", ov, od); end
        tick();
        checks++; if (ov !== 4'b0001 || od[7:0] !== 8'h33 || os[3:0] !== 4'b1000) begin failures++; $display("FAIL bcast_uni got=%b/%h/%b exp=0001/33/1000", ov, od[7:0], os[3:0]); end
        tick();
        checks++; if (ov !== 4'b0000) begin failures++; $display("FAIL bcast_end got=%b exp=0000", ov); end
    endtask

    task automatic test_three_way();
        drive(0, 4'b0110, 8'hCC);
        drive(1, 4'b1100, 8'hDD);
        drive(3, 4'b1111, 8'hEE);
        tick();
        idle();
        tick();
        checks++; if (ov !== 4'b0110 || od[23:8] !== 16'hCCCC) begin failures++; $display("FAIL three_c1 got=%b/%h exp=0110/cccc", ov, od[23:8]); end
        tick();
        checks++; if (ov !== 4'b1100 || od[31:16] !== 16'hDDDD) begin failures++; $display("FAIL three_c2 got=%b/%h exp=1100/dddd", ov, od[31:16]); end
        tick();
        checks++; if (ov !== 4'b1111 || od !== 32'hEEEEEEEE) begin failures++; $display("FAIL three_c3 got=%b/%h exp=1111/eeeeeeee", ov, od); end
        tick();
        checks++; if (ov !== 4'b0000) begin failures++; $display("FAIL three_end got=%b exp=0000", ov); end
    endtask

    task automatic test_filter_self();
        drive(3, 4'b0000, 8'h77);
        tick();
        idle();
        for (int n = 0; n < 3; n++) begin
            tick();
            checks++; if (ov !== 4'b0000) begin failures++; $display("FAIL filter got=%b exp=0000 cyc=%0d", ov, n); end
        end
        drive(3, 4'b1000, 8'h78);
        tick();
        idle();
        tick();
        checks++; if (ov !== 4'b1000 || od[31:24] !== 8'h78) begin failures++; $display("FAIL self_v got=%b/%h exp=1000/78", ov, od[31:24]); end
        checks++; if (os[15:12] !== 4'b1000 || ot[15:12] !== 4'b1000) begin failures++; $display("FAIL self_f got=%b/%b exp=1000/1000", os[15:12], ot[15:12]); end
    endtask

    task automatic test_overflow();
        logic [3:0] ev [10];
        logic [7:0] ed [10];
        ev = '{4'h0, 4'hF, 4'hF, 4'hF, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0};
        ed = '{8'h00, 8'hB1, 8'hB2, 8'hB3, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00};
        drive(0, 4'b0001, 8'h55);
        tick();
        idle();
        tick();
        checks++; if (ov !== 4'b0001 || od[7:0] !== 8'h55) begin failures++; $display("FAIL ovf_warm got=%b/%h exp=0001/55", ov, od[7:0]); end
        for (int s = 0; s < 10; s++) begin
            idle();
            if (s < 5) drive(0, 4'b0010, 8'(s + 1));
            if (s == 0) begin
                drive(1, 4'b1111, 8'hB1);
                drive(2, 4'b1111, 8'hB2);
                drive(3, 4'b1111, 8'hB3);
            end
            tick();
            checks++; if (ov !== ev[s]) begin failures++; $display("FAIL ovf_valid got=%b exp=%b step=%0d", ov, ev[s], s); end
            if (ev[s] == 4'hF) begin
                checks++; if (od !== {4{ed[s]}}) begin failures++; $display("FAIL ovf_bcast got=%h exp=%h step=%0d", od, {4{ed[s]}}, s); end
            end
            if (ev[s] == 4'h2) begin
                checks++; if (od[15:8] !== ed[s]) begin failures++; $display("FAIL ovf_data got=%h exp=%h step=%0d", od[15:8], ed[s], s); end
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(0, 4'b0001, 8'h11);
        drive(1, 4'b0001, 8'h22);
        drive(2, 4'b0001, 8'h33);
        tick();
        idle();
        tick();
        checks++; if (ov !== 4'b0001 || od[7:0] !== 8'h22) begin failures++; $display("FAIL mid_first got=%b/%h exp=0001/22", ov, od[7:0]); end
        #1 rst_n = 1'b1;
        #1;
        checks++; if (ov !== 4'b0000 || od !== 32'h0 || os !== 16'h0) begin failures++; $display("FAIL mid_async got=%b/%h/%h exp=0000/00000000/0000", ov, od, os); end
        tick();
        rst_n = 1'b0;
        for (int n = 0; n < 6; n++) begin
            tick();
            checks++; if (ov !== 4'b0000) begin failures++; $display("FAIL mid_flush got=%b exp=0000 cyc=%0d", ov, n); end
        end
    endtask

    initial begin
        p0.source_in = '0; p0.target_in = '0; p0.data_in = '0;
        p1.source_in = '0; p1.target_in = '0; p1.data_in = '0;
        p2.source_in = '0; p2.target_in = '0; p2.data_in = '0;
        p3.source_in = '0; p3.target_in = '0; p3.data_in = '0;
        idle();
        test_reset();
        test_unicast();
        test_multicast_clash();
        test_bcast_vs_unicast();
        test_three_way();
        test_filter_self();
        test_overflow();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
